// File: rtl/subtrator_serial_if.sv
// Handshake and operand/result bundle between a controller (master) and the
// bit-serial subtractor (slave).
interface subtrator_serial_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out, overflow
   );
endinterface

// File: rtl/subtrator_serial.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB
// first, with a registered borrow; results appear together on the done pulse.
module subtrator_serial #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   subtrator_serial_if.slave bus
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] aShift_q, aShift_d;
   logic [WIDTH-1:0] bShift_q, bShift_d;
   logic [WIDTH-2:0] resShift_q, resShift_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    count_q, count_d;
   logic             aMsb_q, aMsb_d;
   logic             bMsb_q, bMsb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrowOut_q, borrowOut_d;
   logic             overflow_q, overflow_d;

   logic             aBit, bBit, diffBit, borrowNext;
   logic [WIDTH-1:0] shiftIn;

   assign aBit       = aShift_q[0];
   assign bBit       = bShift_q[0];
   assign diffBit    = aBit ^ bBit ^ borrow_q;
   assign borrowNext = (~aBit & bBit) | (~(aBit ^ bBit) & borrow_q);
   // Result bits enter from the MSB; the last bit completes the word directly.
   assign shiftIn    = {diffBit, resShift_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         aShift_q    <= '0;
         bShift_q    <= '0;
         resShift_q  <= '0;
         borrow_q    <= 1'b0;
         count_q     <= '0;
         aMsb_q      <= 1'b0;
         bMsb_q      <= 1'b0;
         diff_q      <= '0;
         borrowOut_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         aShift_q    <= aShift_d;
         bShift_q    <= bShift_d;
         resShift_q  <= resShift_d;
         borrow_q    <= borrow_d;
         count_q     <= count_d;
         aMsb_q      <= aMsb_d;
         bMsb_q      <= bMsb_d;
         diff_q      <= diff_d;
         borrowOut_q <= borrowOut_d;
         overflow_q  <= overflow_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      aShift_d    = aShift_q;
      bShift_d    = bShift_q;
      resShift_d  = resShift_q;
      borrow_d    = borrow_q;
      count_d     = count_q;
      aMsb_d      = aMsb_q;
      bMsb_d      = bMsb_q;
      diff_d      = diff_q;
      borrowOut_d = borrowOut_q;
      overflow_d  = overflow_q;

      case (state_q)
         RUN: begin
            aShift_d   = aShift_q >> 1;
            bShift_d   = bShift_q >> 1;
            resShift_d = shiftIn[WIDTH-1:1];
            borrow_d   = borrowNext;
            count_d    = count_q + 1'b1;
            if (count_q == LAST) begin
               state_d     = DONE;
               diff_d      = shiftIn;
               borrowOut_d = borrowNext;
               overflow_d  = (aMsb_q != bMsb_q) && (diffBit != aMsb_q);
            end
         end
         default: begin
            // IDLE and DONE both accept a request, allowing back-to-back runs.
            if (bus.start) begin
               state_d  = RUN;
               aShift_d = bus.a;
               bShift_d = bus.b;
               borrow_d = 1'b0;
               count_d  = '0;
               aMsb_d   = bus.a[WIDTH-1];
               bMsb_d   = bus.b[WIDTH-1];
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   assign bus.busy       = (state_q == RUN);
   assign bus.done       = (state_q == DONE);
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrowOut_q;
   assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial: a cycle-level arithmetic model is
// compared every cycle, plus directed operations with hand-computed results.
module tb_subtrator_serial;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   subtrator_serial_if #(.WIDTH(8)) bus();

   subtrator_serial #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic bit signedOverflow(input logic [7:0] a, input logic [7:0] b);
      byte sa, sb;
      int  r;
      sa = a;
      sb = b;
      r  = int'(sa) - int'(sb);
      return (r > 127) || (r < -128);
   endfunction

   // Timing model: an accepted request keeps the unit busy for 8 edges, then
   // one done cycle carries the arithmetic result of the captured operands.
   int         mRemain;
   logic       mDone;
   logic [7:0] mDiff, pDiff;
   logic       mBorrow, pBorrow, mOvf, pOvf;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mRemain <= 0;
         mDone   <= 1'b0;
         mDiff   <= 8'h00;
         mBorrow <= 1'b0;
         mOvf    <= 1'b0;
      end else if (mRemain > 0) begin
         mRemain <= mRemain - 1;
         if (mRemain == 1) begin
            mDone   <= 1'b1;
            mDiff   <= pDiff;
            mBorrow <= pBorrow;
            mOvf    <= pOvf;
         end
      end else begin
         mDone <= 1'b0;
         if (bus.start) begin
            mRemain <= 8;
            pDiff   <= bus.a - bus.b;
            pBorrow <= (bus.a < bus.b);
            pOvf    <= signedOverflow(bus.a, bus.b);
         end
      end
   end

   always @(negedge clk) begin
      checkOutput("model busy",     32'(bus.busy),       32'(mRemain > 0));
      checkOutput("model done",     32'(bus.done),       32'(mDone));
      checkOutput("model diff",     32'(bus.diff),       32'(mDiff));
      checkOutput("model borrow",   32'(bus.borrow_out), 32'(mBorrow));
      checkOutput("model overflow", 32'(bus.overflow),   32'(mOvf));
   end

   task automatic waitResult(input string tag, input logic [7:0] expDiff, input logic expB, input logic expO);
      int busyCnt = 0;
      bit found   = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (bus.done) found = 1'b1;
         else begin
            if (bus.busy) busyCnt++;
            @(negedge clk);
         end
      end
      checkOutput({tag, " done seen"}, 32'(found), 32'd1);
      checkOutput({tag, " busy cycles"}, 32'(busyCnt), 32'd8);
      checkOutput({tag, " diff"}, 32'(bus.diff), 32'(expDiff));
      checkOutput({tag, " borrow"}, 32'(bus.borrow_out), 32'(expB));
      checkOutput({tag, " overflow"}, 32'(bus.overflow), 32'(expO));
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a     = 8'h00;
      bus.b     = 8'h00;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset done", 32'(bus.done), 32'd0);
      checkOutput("reset diff", 32'(bus.diff), 32'd0);
      rst = 1'b0;

      applyStimulus(8'h05, 8'h03);
      waitResult("05-03", 8'h02, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("done pulse width", 32'(bus.done), 32'd0);
      checkOutput("diff held", 32'(bus.diff), 32'h02);

      applyStimulus(8'h03, 8'h05);
      waitResult("03-05", 8'hFE, 1'b1, 1'b0);
      applyStimulus(8'h80, 8'h01);
      waitResult("80-01", 8'h7F, 1'b0, 1'b1);
      applyStimulus(8'h7F, 8'hFF);
      waitResult("7F-FF", 8'h80, 1'b1, 1'b1);

      // Abort mid-run with reset asserted between clock edges.
      applyStimulus(8'hAA, 8'h55);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort busy", 32'(bus.busy), 32'd0);
      checkOutput("abort done", 32'(bus.done), 32'd0);
      checkOutput("abort diff", 32'(bus.diff), 32'd0);
      checkOutput("abort borrow", 32'(bus.borrow_out), 32'd0);
      checkOutput("abort overflow", 32'(bus.overflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(8'h09, 8'h09);
      waitResult("09-09", 8'h00, 1'b0, 1'b0);

      // Ignored start during RUN, then start held through DONE.
      applyStimulus(8'h10, 8'h01);
      repeat (2) @(negedge clk);
      bus.a     = 8'hFF;
      bus.b     = 8'h00;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.a     = 8'h20;
      bus.b     = 8'h20;
      bus.start = 1'b1;
      @(negedge clk);
      checkOutput("10-01 done", 32'(bus.done), 32'd1);
      checkOutput("10-01 diff", 32'(bus.diff), 32'h0F);
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("b2b busy", 32'(bus.busy), 32'd1);
      waitResult("20-20", 8'h00, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
